// File: rtl/rvdx_pkg.sv
// Shared decode definitions for the RV32I decode/execute slice: opcodes,
// ALU operations, operand selects, immediate formats and next-PC encodings.
package rvdx_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] NPC_SEQ    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JAL    = 2'b10;
    localparam logic [1:0] NPC_JALR   = 2'b11;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_fmt_t;

    typedef enum logic [1:0] {A_ZERO, A_RS1, A_PC} a_sel_t;
    typedef enum logic [1:0] {B_ZERO, B_RS2, B_IMM, B_FOUR} b_sel_t;

    // sub: funct7[5] may select SUB (R-type only); arith: funct7[5] selects SRA.
    function automatic alu_op_t alu_decode(input logic [2:0] funct3,
                                           input logic sub,
                                           input logic arith);
        case (funct3)
            3'b000:  return sub ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return arith ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rvdx_regfile.sv
// 32-entry register file: two combinational read ports without write bypass,
// one write port, asynchronous active-low clear; x0 reads as zero.
module rvdx_regfile
    import rvdx_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4:0]            rs1_addr,
    input  logic [4:0]            rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  write,
    input  logic [4:0]            write_reg,
    input  logic [DATA_WIDTH-1:0] write_data
);

    logic [DATA_WIDTH-1:0] regs [32];

    // NOTE: the whole array is cleared on reset because software relies on
    // zeroed registers, so this maps to flops rather than a RAM macro.
    // NOTE: non-blocking assignments keep every read this cycle on old state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (write && write_reg != 5'd0) begin
            regs[write_reg] <= write_data;
        end
    end

    assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];

endmodule

// File: rtl/rv32i_decode_execute.sv
// RV32I single-cycle decode, control, ALU and next-PC target generation.
// Define RVDX_PERF_EN to add saturating cycle / taken-branch counters with report output.
module rv32i_decode_execute
    import rvdx_pkg::*;
#(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [31:0]             instruction,
    input  logic [ADDRESS_BITS-1:0] PC,
    input  logic                    write,
    input  logic [4:0]              write_reg,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic                    report,
    output logic [4:0]              rd,
    output logic [DATA_WIDTH-1:0]   rs2_data,
    output logic [DATA_WIDTH-1:0]   ALU_result,
    output logic                    branch,
    output logic [1:0]              next_PC_sel,
    output logic [ADDRESS_BITS-1:0] branch_target,
    output logic [ADDRESS_BITS-1:0] JAL_target,
    output logic [ADDRESS_BITS-1:0] JALR_target,
    output logic                    memRead,
    output logic                    memWrite,
    output logic                    memtoReg,
    output logic                    regWrite
);

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] pc_ext;
    logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
    logic [DATA_WIDTH-1:0] alu_a, alu_b, jalr_sum;
    logic [4:0]            shamt;
    logic                  br_cond;
    alu_op_t               alu_op;
    imm_fmt_t              imm_fmt;
    a_sel_t                a_sel;
    b_sel_t                b_sel;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign rd     = instruction[11:7];
    assign pc_ext = DATA_WIDTH'(PC);

    rvdx_regfile #(.DATA_WIDTH(DATA_WIDTH)) u_regfile (
        .clock      (clock),
        .reset      (reset),
        .rs1_addr   (instruction[19:15]),
        .rs2_addr   (instruction[24:20]),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .write      (write),
        .write_reg  (write_reg),
        .write_data (write_data)
    );

    assign imm_i = DATA_WIDTH'($signed(instruction[31:20]));
    assign imm_s = DATA_WIDTH'($signed({instruction[31:25], instruction[11:7]}));
    assign imm_b = DATA_WIDTH'($signed({instruction[31], instruction[7],
                                        instruction[30:25], instruction[11:8], 1'b0}));
    assign imm_u = DATA_WIDTH'($signed({instruction[31:12], 12'b0}));
    assign imm_j = DATA_WIDTH'($signed({instruction[31], instruction[19:12],
                                        instruction[20], instruction[30:21], 1'b0}));

    // NOTE: every output of a combinational block gets a default first, so
    // opcodes that do not mention a signal can never infer a latch.
    always_comb begin
        a_sel       = A_ZERO;
        b_sel       = B_ZERO;
        imm_fmt     = IMM_NONE;
        alu_op      = ALU_ADD;
        next_PC_sel = NPC_SEQ;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        memtoReg    = 1'b0;
        regWrite    = 1'b0;
        case (opcode)
            OP_R: begin
                a_sel    = A_RS1;
                b_sel    = B_RS2;
                alu_op   = alu_decode(funct3, instruction[30], instruction[30]);
                regWrite = 1'b1;
            end
            OP_IMM: begin
                a_sel    = A_RS1;
                b_sel    = B_IMM;
                imm_fmt  = IMM_I;
                alu_op   = alu_decode(funct3, 1'b0, instruction[30]);
                regWrite = 1'b1;
            end
            OP_LOAD: begin
                a_sel    = A_RS1;
                b_sel    = B_IMM;
                imm_fmt  = IMM_I;
                memRead  = 1'b1;
                memtoReg = 1'b1;
                regWrite = 1'b1;
            end
            OP_STORE: begin
                a_sel    = A_RS1;
                b_sel    = B_IMM;
                imm_fmt  = IMM_S;
                memWrite = 1'b1;
            end
            OP_BRANCH: begin
                a_sel       = A_RS1;
                b_sel       = B_RS2;
                alu_op      = ALU_SUB;
                next_PC_sel = NPC_BRANCH;
            end
            OP_JAL, OP_JALR: begin
                a_sel       = A_PC;
                b_sel       = B_FOUR;
                next_PC_sel = (opcode == OP_JAL) ? NPC_JAL : NPC_JALR;
                regWrite    = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                a_sel    = (opcode == OP_AUIPC) ? A_PC : A_ZERO;
                b_sel    = B_IMM;
                imm_fmt  = IMM_U;
                regWrite = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (imm_fmt)
            IMM_I:   imm = imm_i;
            IMM_S:   imm = imm_s;
            IMM_B:   imm = imm_b;
            IMM_U:   imm = imm_u;
            IMM_J:   imm = imm_j;
            default: imm = '0;
        endcase
        case (a_sel)
            A_RS1:   alu_a = rs1_data;
            A_PC:    alu_a = pc_ext;
            default: alu_a = '0;
        endcase
        case (b_sel)
            B_RS2:   alu_b = rs2_data;
            B_IMM:   alu_b = imm;
            B_FOUR:  alu_b = DATA_WIDTH'(4);
            default: alu_b = '0;
        endcase
    end

    assign shamt = alu_b[4:0];

    always_comb begin
        ALU_result = '0;
        case (alu_op)
            ALU_ADD:  ALU_result = alu_a + alu_b;
            ALU_SUB:  ALU_result = alu_a - alu_b;
            ALU_SLL:  ALU_result = alu_a << shamt;
            ALU_SLT:  ALU_result = DATA_WIDTH'($signed(alu_a) < $signed(alu_b));
            ALU_SLTU: ALU_result = DATA_WIDTH'(alu_a < alu_b);
            ALU_XOR:  ALU_result = alu_a ^ alu_b;
            ALU_SRL:  ALU_result = alu_a >> shamt;
            ALU_SRA:  ALU_result = DATA_WIDTH'($signed(alu_a) >>> shamt);
            ALU_OR:   ALU_result = alu_a | alu_b;
            ALU_AND:  ALU_result = alu_a & alu_b;
            default:  ALU_result = '0;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000:  br_cond = (rs1_data == rs2_data);
            3'b001:  br_cond = (rs1_data != rs2_data);
            3'b100:  br_cond = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  br_cond = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  br_cond = (rs1_data <  rs2_data);
            3'b111:  br_cond = (rs1_data >= rs2_data);
            default: br_cond = 1'b0;
        endcase
    end

    assign branch = (opcode == OP_BRANCH) && br_cond;

    // Targets are formed at full data width and truncated to the PC width.
    assign jalr_sum      = rs1_data + imm_i;
    assign branch_target = ADDRESS_BITS'(pc_ext + imm_b);
    assign JAL_target    = ADDRESS_BITS'(pc_ext + imm_j);
    assign JALR_target   = {jalr_sum[ADDRESS_BITS-1:1], 1'b0};

`ifdef RVDX_PERF_EN
    logic [31:0] cycle_count;
    logic [31:0] taken_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
            taken_count <= '0;
        end else begin
            if (cycle_count != '1) cycle_count <= cycle_count + 32'd1;
            if (branch && next_PC_sel == NPC_BRANCH && taken_count != '1)
                taken_count <= taken_count + 32'd1;
            if (report)
                $display("core %0d: %0d cycles, %0d taken branches",
                         CORE, cycle_count, taken_count);
        end
    end
`else
    logic unused_report;
    assign unused_report = report;
`endif

endmodule

// File: tb/tb_rv32i_decode_execute.sv
// Self-checking bench for rv32i_decode_execute: directed vector table,
// hand-written register-file sequences and randomized instructions vs. an ISA model.
module tb_rv32i_decode_execute;

    localparam logic [6:0] R_OP   = 7'b0110011;
    localparam logic [6:0] I_OP   = 7'b0010011;
    localparam logic [6:0] LD_OP  = 7'b0000011;
    localparam logic [6:0] ST_OP  = 7'b0100011;
    localparam logic [6:0] BR_OP  = 7'b1100011;
    localparam logic [6:0] JAL_OP = 7'b1101111;
    localparam logic [6:0] JR_OP  = 7'b1100111;
    localparam logic [6:0] LUI_OP = 7'b0110111;
    localparam logic [6:0] AUI_OP = 7'b0010111;

    logic        clock;
    logic        reset;
    logic [31:0] instruction;
    logic [9:0]  PC;
    logic        write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        report;
    logic [4:0]  rd;
    logic [31:0] rs2_data;
    logic [31:0] ALU_result;
    logic        branch;
    logic [1:0]  next_PC_sel;
    logic [9:0]  branch_target;
    logic [9:0]  JAL_target;
    logic [9:0]  JALR_target;
    logic        memRead;
    logic        memWrite;
    logic        memtoReg;
    logic        regWrite;

    rv32i_decode_execute #(.CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(10)) dut (
        .clock         (clock),
        .reset         (reset),
        .instruction   (instruction),
        .PC            (PC),
        .write         (write),
        .write_reg     (write_reg),
        .write_data    (write_data),
        .report        (report),
        .rd            (rd),
        .rs2_data      (rs2_data),
        .ALU_result    (ALU_result),
        .branch        (branch),
        .next_PC_sel   (next_PC_sel),
        .branch_target (branch_target),
        .JAL_target    (JAL_target),
        .JALR_target   (JALR_target),
        .memRead       (memRead),
        .memWrite      (memWrite),
        .memtoReg      (memtoReg),
        .regWrite      (regWrite)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    logic [31:0] model_regs [32];

    typedef struct {
        logic [31:0] alu;
        logic        check_alu;
        logic        br;
        logic [1:0]  sel;
        logic [3:0]  ctrl;      // {memRead, memWrite, memtoReg, regWrite}
        logic [31:0] rs2d;
        logic [4:0]  rd;
        logic [9:0]  btgt;
        logic [9:0]  jtgt;
        logic [9:0]  jrtgt;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [9:0]  pc;
        logic        check_alu;
        logic [31:0] alu;
        logic        br;
        logic [1:0]  sel;
        logic [3:0]  ctrl;
        int          tkind;     // 0 none, 1 branch, 2 JAL, 3 JALR target
        logic [9:0]  tgt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rdi, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rdi, op};
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rdi,
                                          input logic [6:0] op);
        logic [31:0] v = imm;
        return {v[11:0], rs1, f3, rdi, op};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        logic [31:0] v = imm;
        return {v[11:5], rs2, rs1, f3, v[4:0], ST_OP};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        logic [31:0] v = imm;
        return {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], BR_OP};
    endfunction

    function automatic logic [31:0] enc_u(input int imm20, input logic [4:0] rdi,
                                          input logic [6:0] op);
        logic [31:0] v = imm20;
        return {v[19:0], rdi, op};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input logic [4:0] rdi);
        logic [31:0] v = imm;
        return {v[20], v[10:1], v[11], v[19:12], rdi, JAL_OP};
    endfunction

    // ISA semantics of one arithmetic operation selected by funct3.
    function automatic logic [31:0] isa_alu(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b, input logic sub,
                                            input logic arith);
        case (f3)
            3'd0:    return sub ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return arith ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic exp_t ref_model(input logic [31:0] inst, input logic [9:0] pc);
        exp_t        e;
        logic [31:0] a, b, ii, is, ib, iu, ij, pc32, jr;
        logic [2:0]  f3;
        a    = model_regs[inst[19:15]];
        b    = model_regs[inst[24:20]];
        f3   = inst[14:12];
        ii   = {{20{inst[31]}}, inst[31:20]};
        is   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        ib   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        iu   = {inst[31:12], 12'b0};
        ij   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        pc32 = {22'b0, pc};
        jr   = a + ii;
        e.alu = 32'd0; e.check_alu = 1'b1; e.br = 1'b0; e.sel = 2'd0; e.ctrl = 4'b0000;
        e.rs2d  = b;
        e.rd    = inst[11:7];
        e.btgt  = 10'(pc32 + ib);
        e.jtgt  = 10'(pc32 + ij);
        e.jrtgt = {jr[9:1], 1'b0};
        case (inst[6:0])
            R_OP:   begin e.alu = isa_alu(f3, a, b, inst[30], inst[30]); e.ctrl = 4'b0001; end
            I_OP:   begin e.alu = isa_alu(f3, a, ii, 1'b0, inst[30]);    e.ctrl = 4'b0001; end
            LD_OP:  begin e.alu = a + ii;    e.ctrl = 4'b1011; end
            ST_OP:  begin e.alu = a + is;    e.ctrl = 4'b0100; end
            JAL_OP: begin e.alu = pc32 + 4;  e.ctrl = 4'b0001; e.sel = 2'd2; end
            JR_OP:  begin e.alu = pc32 + 4;  e.ctrl = 4'b0001; e.sel = 2'd3; end
            LUI_OP: begin e.alu = iu;        e.ctrl = 4'b0001; end
            AUI_OP: begin e.alu = pc32 + iu; e.ctrl = 4'b0001; end
            BR_OP: begin
                e.sel = 2'd1;
                e.check_alu = 1'b0;
                case (f3)
                    3'd0: e.br = (a == b);
                    3'd1: e.br = (a != b);
                    3'd4: e.br = ($signed(a) <  $signed(b));
                    3'd5: e.br = ($signed(a) >= $signed(b));
                    3'd6: e.br = (a <  b);
                    3'd7: e.br = (a >= b);
                    default: e.br = 1'b0;
                endcase
            end
            default: ;
        endcase
        return e;
    endfunction

    // Called right after a rising edge; leaves the bench right after the next one.
    task automatic do_write(input logic [4:0] idx, input logic [31:0] val);
        write = 1'b1; write_reg = idx; write_data = val;
        @(posedge clock);
        #1;
        write = 1'b0;
        if (idx != 5'd0) model_regs[idx] = val;
    endtask

    task automatic compare_all(input string tag, input exp_t e);
        if (e.check_alu) check({tag, ".ALU_result"}, ALU_result, e.alu);
        check({tag, ".branch"},        32'(branch),        32'(e.br));
        check({tag, ".next_PC_sel"},   32'(next_PC_sel),   32'(e.sel));
        check({tag, ".ctrl"},          32'({memRead, memWrite, memtoReg, regWrite}), 32'(e.ctrl));
        check({tag, ".rd"},            32'(rd),            32'(e.rd));
        check({tag, ".rs2_data"},      rs2_data,           e.rs2d);
        check({tag, ".branch_target"}, 32'(branch_target), 32'(e.btgt));
        check({tag, ".JAL_target"},    32'(JAL_target),    32'(e.jtgt));
        check({tag, ".JALR_target"},   32'(JALR_target),   32'(e.jrtgt));
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [9] = '{R_OP, I_OP, LD_OP, ST_OP, BR_OP, JAL_OP, JR_OP, LUI_OP, AUI_OP};
        logic [6:0]  op;
        logic [31:0] r;
        logic        known;
        op = ops[$urandom_range(0, 8)];
        if ($urandom_range(0, 9) == 0) begin
            do begin
                op = 7'($urandom);
                known = 1'b0;
                foreach (ops[k]) if (ops[k] == op) known = 1'b1;
            end while (known);
        end
        r = $urandom;
        return {r[31:7], op};
    endfunction

    task automatic add_vec(input string name, input logic [31:0] inst, input logic [9:0] pc,
                           input logic check_alu, input logic [31:0] alu, input logic br,
                           input logic [1:0] sel, input logic [3:0] ctrl, input int tkind,
                           input logic [9:0] tgt);
        vec_t v;
        v = '{name, inst, pc, check_alu, alu, br, sel, ctrl, tkind, tgt};
        vecs.push_back(v);
    endtask

    initial begin
        exp_t e;
        add_vec("sub_x7",   enc_r(7'h20, 6, 5, 3'd0, 7, R_OP), 10'h000, 1, 32'd4,        0, 2'd0, 4'b0001, 0, 10'h0);
        add_vec("srai_2",   enc_i(32'h402, 1, 3'd5, 3, I_OP),  10'h000, 1, 32'hFFFFFFFE, 0, 2'd0, 4'b0001, 0, 10'h0);
        add_vec("srli_2",   enc_i(32'h002, 1, 3'd5, 3, I_OP),  10'h000, 1, 32'h3FFFFFFE, 0, 2'd0, 4'b0001, 0, 10'h0);
        add_vec("sltu",     enc_r(7'h00, 2, 1, 3'd3, 3, R_OP), 10'h000, 1, 32'd0,        0, 2'd0, 4'b0001, 0, 10'h0);
        add_vec("slt",      enc_r(7'h00, 2, 1, 3'd2, 3, R_OP), 10'h000, 1, 32'd1,        0, 2'd0, 4'b0001, 0, 10'h0);
        add_vec("blt",      enc_b(-16, 13, 12, 3'd4),          10'h040, 0, 32'd0,        1, 2'd1, 4'b0000, 1, 10'h030);
        add_vec("bgeu",     enc_b(-16, 13, 12, 3'd7),          10'h040, 0, 32'd0,        1, 2'd1, 4'b0000, 1, 10'h030);
        add_vec("beq_nt",   enc_b(8, 6, 5, 3'd0),              10'h040, 0, 32'd0,        0, 2'd1, 4'b0000, 1, 10'h048);
        add_vec("bfunct3_2",enc_b(8, 5, 5, 3'd2),              10'h040, 0, 32'd0,        0, 2'd1, 4'b0000, 0, 10'h0);
        add_vec("jal",      enc_j(8, 1),                       10'h100, 1, 32'h104,      0, 2'd2, 4'b0001, 2, 10'h108);
        add_vec("jalr",     enc_i(2, 11, 3'd0, 3, JR_OP),      10'h100, 1, 32'h104,      0, 2'd3, 4'b0001, 3, 10'h022);
        add_vec("sw",       enc_s(-4, 5, 10, 3'd2),            10'h000, 1, 32'h7C,       0, 2'd0, 4'b0100, 0, 10'h0);
        add_vec("lw",       enc_i(4, 10, 3'd2, 3, LD_OP),      10'h000, 1, 32'h84,       0, 2'd0, 4'b1011, 0, 10'h0);
        add_vec("lui",      enc_u(32'h12345, 4, LUI_OP),       10'h000, 1, 32'h12345000, 0, 2'd0, 4'b0001, 0, 10'h0);
        add_vec("auipc",    enc_u(1, 4, AUI_OP),               10'h100, 1, 32'h00001100, 0, 2'd0, 4'b0001, 0, 10'h0);
        add_vec("unknown",  32'hFFFFFFFF,                      10'h100, 1, 32'd0,        0, 2'd0, 4'b0000, 0, 10'h0);

        foreach (model_regs[i]) model_regs[i] = 32'd0;
        reset = 1'b0; write = 1'b0; write_reg = 5'd0; write_data = 32'd0; report = 1'b0;
        PC = 10'h0;
        instruction = enc_r(7'h00, 6, 5, 3'd0, 3, R_OP);

        // Outputs follow the instruction while reset holds the registers at zero.
        @(negedge clock);
        check("reset.ALU_result", ALU_result, 32'd0);
        check("reset.rs2_data",   rs2_data,   32'd0);
        check("reset.regWrite",   32'(regWrite), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;

        do_write(5, 32'd7);
        do_write(6, 32'd3);
        do_write(0, 32'd55);
        instruction = enc_r(7'h00, 0, 0, 3'd0, 3, R_OP);
        @(negedge clock);
        check("x0.rs2_data",   rs2_data,   32'd0);
        check("x0.ALU_result", ALU_result, 32'd0);
        @(posedge clock);
        #1;

        // Same-cycle write is not forwarded; the new value appears after the edge.
        instruction = enc_r(7'h00, 5, 0, 3'd0, 3, R_OP);
        write = 1'b1; write_reg = 5'd5; write_data = 32'd99;
        @(negedge clock);
        check("nobypass.old", rs2_data, 32'd7);
        @(posedge clock);
        #1;
        write = 1'b0;
        model_regs[5] = 32'd99;
        @(negedge clock);
        check("nobypass.new",    rs2_data,   32'd99);
        check("nobypass.result", ALU_result, 32'd99);
        @(posedge clock);
        #1;

        reset = 1'b0;
        #1;
        check("async_reset.x5", rs2_data, 32'd0);
        foreach (model_regs[i]) model_regs[i] = 32'd0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        do_write(1, 32'hFFFFFFF8);
        do_write(2, 32'd1);
        do_write(5, 32'd7);
        do_write(6, 32'd3);
        do_write(10, 32'h80);
        do_write(11, 32'h21);
        do_write(12, 32'hFFFFFFFF);
        do_write(13, 32'd1);

        foreach (vecs[i]) begin
            instruction = vecs[i].inst;
            PC = vecs[i].pc;
            @(negedge clock);
            if (vecs[i].check_alu) check({vecs[i].name, ".ALU_result"}, ALU_result, vecs[i].alu);
            check({vecs[i].name, ".branch"},      32'(branch),      32'(vecs[i].br));
            check({vecs[i].name, ".next_PC_sel"}, 32'(next_PC_sel), 32'(vecs[i].sel));
            check({vecs[i].name, ".ctrl"}, 32'({memRead, memWrite, memtoReg, regWrite}), 32'(vecs[i].ctrl));
            case (vecs[i].tkind)
                1: check({vecs[i].name, ".branch_target"}, 32'(branch_target), 32'(vecs[i].tgt));
                2: check({vecs[i].name, ".JAL_target"},    32'(JAL_target),    32'(vecs[i].tgt));
                3: check({vecs[i].name, ".JALR_target"},   32'(JALR_target),   32'(vecs[i].tgt));
                default: ;
            endcase
            @(posedge clock);
            #1;
        end

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                logic [31:0] val;
                val = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
                do_write(5'($urandom), val);
            end
            instruction = rand_inst();
            PC = 10'($urandom);
            @(negedge clock);
            e = ref_model(instruction, PC);
            compare_all($sformatf("rand%0d", n), e);
            @(posedge clock);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
